// File: rtl/i2c_target_regfile.sv
`timescale 1ns/1ps
// i2c_target_regfile
//   I2C target with a small byte-wide register file. The master sets a
//   register pointer, then either writes or reads a burst of bytes. The
//   pointer auto-increments and wraps. A local combinational read port and
//   a write-notify strobe connect the registers to on-chip logic.
// Ports
//   clk       system clock, at least 16x the SCL rate
//   reset_n   asynchronous active-low reset
//   scl       bus clock from the master
//   sda       open-drain bus data; only 1'b0 or 1'bz is driven from here
//   rd_idx    local read-port index
//   rd_data   contents of register rd_idx (combinational)
//   wr_valid  one-clk pulse per data byte written by the master
//   wr_idx    register written, valid with wr_valid
//   wr_data   byte written, valid with wr_valid
//   busy      high from an address match until STOP or a NACK ends the read
module i2c_target_regfile #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NUM_REGS    = 4,
  localparam int unsigned PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl,
  inout  wire           sda,
  input  logic [PW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          wr_valid,
  output logic [PW-1:0] wr_idx,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
  } state_t;

  state_t        state_r, next_state_s;
  logic          scl_meta_r, scl_sync_r, scl_prev_r;
  logic          sda_meta_r, sda_sync_r, sda_prev_r;
  logic [3:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [6:0]    shift_r, shift_nxt_s;
  logic [7:0]    tx_r, tx_nxt_s;
  logic [PW-1:0] ptr_r, ptr_nxt_s, ptr_inc_s;
  logic          sda_oe_r, sda_oe_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic          rw_r, rw_nxt_s;
  logic          reg_we_s;
  logic          wr_valid_r;
  logic [PW-1:0] wr_idx_r;
  logic [7:0]    wr_data_r;
  logic [7:0]    regs_r [NUM_REGS];
  logic [7:0]    byte_s, cur_byte_s, next_byte_s;
  logic          scl_rise_s, scl_fall_s, start_s, stop_s, last_bit_s;

  // Bus conditioning: the sync flop of each line is what the protocol uses;
  // reset to 1 so an idle bus looks idle and no false START/STOP appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {scl_meta_r, scl_sync_r, scl_prev_r} <= 3'b111;
      {sda_meta_r, sda_sync_r, sda_prev_r} <= 3'b111;
    end else begin
      {scl_meta_r, scl_sync_r, scl_prev_r} <= {scl, scl_meta_r, scl_sync_r};
      {sda_meta_r, sda_sync_r, sda_prev_r} <= {sda, sda_meta_r, sda_sync_r};
    end
  end

  assign scl_rise_s  = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s  = ~scl_sync_r & scl_prev_r;
  // START/STOP require SCL high in both samples so SDA moves near an SCL
  // edge are never mistaken for a bus condition.
  assign start_s     = scl_sync_r & scl_prev_r & ~sda_sync_r & sda_prev_r;
  assign stop_s      = scl_sync_r & scl_prev_r & sda_sync_r & ~sda_prev_r;
  assign byte_s      = {shift_r, sda_sync_r};
  assign last_bit_s  = (bit_cnt_r == 4'd7);
  assign ptr_inc_s   = ptr_r + PW'(1);
  assign cur_byte_s  = regs_r[ptr_r];
  assign next_byte_s = regs_r[ptr_inc_s];

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= next_state_s;
  end

  // Next-state and datapath control; STOP beats START beats bit events.
  always_comb begin
    next_state_s  = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    tx_nxt_s      = tx_r;
    ptr_nxt_s     = ptr_r;
    sda_oe_nxt_s  = sda_oe_r;
    busy_nxt_s    = busy_r;
    rw_nxt_s      = rw_r;
    reg_we_s      = 1'b0;
    if (stop_s) begin
      next_state_s  = ST_IDLE;
      bit_cnt_nxt_s = 4'd0;
      sda_oe_nxt_s  = 1'b0;
      busy_nxt_s    = 1'b0;
    end else if (start_s) begin
      // Also the repeated-START path: a partial byte is dropped, pointer kept.
      next_state_s  = ST_ADDR;
      bit_cnt_nxt_s = 4'd0;
      sda_oe_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_s) begin
            shift_nxt_s   = byte_s[6:0];
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if (last_bit_s) begin
              bit_cnt_nxt_s = 4'd0;
              case (state_r)
                ST_ADDR: begin
                  // Address 0 (general call) is never acknowledged.
                  if ((byte_s[7:1] == TARGET_ADDR) && (byte_s[7:1] != 7'h00)) begin
                    next_state_s = ST_ADDR_ACK;
                    busy_nxt_s   = 1'b1;
                    rw_nxt_s     = byte_s[0];
                  end else begin
                    next_state_s = ST_WAIT_STOP;
                    busy_nxt_s   = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_nxt_s    = byte_s[PW-1:0];
                  next_state_s = ST_PTR_ACK;
                end
                ST_WDATA: begin
                  reg_we_s     = 1'b1;
                  ptr_nxt_s    = ptr_inc_s;
                  next_state_s = ST_WDATA_ACK;
                end
                default: next_state_s = ST_IDLE;
              endcase
            end else begin
              next_state_s = state_r;
            end
          end else begin
            next_state_s = state_r;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First falling edge pulls SDA low, the second one ends the ACK.
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_nxt_s = 1'b1;
            end else begin
              sda_oe_nxt_s  = 1'b0;
              bit_cnt_nxt_s = 4'd0;
              case (state_r)
                ST_ADDR_ACK: begin
                  if (rw_r) begin
                    // Read: the MSB goes out on this same falling edge.
                    next_state_s  = ST_RDATA;
                    tx_nxt_s      = {cur_byte_s[6:0], 1'b0};
                    sda_oe_nxt_s  = ~cur_byte_s[7];
                    bit_cnt_nxt_s = 4'd1;
                  end else begin
                    next_state_s = ST_PTR;
                  end
                end
                ST_PTR_ACK, ST_WDATA_ACK: next_state_s = ST_WDATA;
                default:                  next_state_s = ST_IDLE;
              endcase
            end
          end else begin
            next_state_s = state_r;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s) begin
            if (bit_cnt_r != 4'd8) begin
              sda_oe_nxt_s  = ~tx_r[7];
              tx_nxt_s      = {tx_r[6:0], 1'b0};
              bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            end else begin
              sda_oe_nxt_s  = 1'b0;
              bit_cnt_nxt_s = 4'd0;
              next_state_s  = ST_RDATA_ACK;
            end
          end else begin
            next_state_s = state_r;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            if (!sda_sync_r) begin
              ptr_nxt_s     = ptr_inc_s;
              tx_nxt_s      = next_byte_s;
              bit_cnt_nxt_s = 4'd0;
              next_state_s  = ST_RDATA;
            end else begin
              next_state_s = ST_WAIT_STOP;
              busy_nxt_s   = 1'b0;
            end
          end else begin
            next_state_s = state_r;
          end
        end
        ST_IDLE, ST_WAIT_STOP: next_state_s = state_r;
        default: begin
          next_state_s = ST_IDLE;
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers, register file and write-notify outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 7'h00;
      tx_r       <= 8'h00;
      ptr_r      <= '0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      rw_r       <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_idx_r   <= '0;
      wr_data_r  <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 8'h00;
    end else begin
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_r       <= tx_nxt_s;
      ptr_r      <= ptr_nxt_s;
      sda_oe_r   <= sda_oe_nxt_s;
      busy_r     <= busy_nxt_s;
      rw_r       <= rw_nxt_s;
      wr_valid_r <= reg_we_s;
      if (reg_we_s) begin
        regs_r[ptr_r] <= byte_s;
        wr_idx_r      <= ptr_r;
        wr_data_r     <= byte_s;
      end
    end
  end

  assign sda      = sda_oe_r ? 1'b0 : 1'bz;
  assign rd_data  = regs_r[rd_idx];
  assign wr_valid = wr_valid_r;
  assign wr_idx   = wr_idx_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
// Directed bench for i2c_target_regfile: a bit-banged I2C master with
// SCL = 32 clk periods, checking ACKs, read data, register contents and the
// write-notify strobe against hand-computed values.
module tb_i2c_target_regfile;

  localparam int Q = 80;  // quarter SCL period, 8 clk

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;   // master pulls SDA low when set
  logic [1:0] rd_idx = 2'd0;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [1:0] wr_idx;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_target_regfile #(.TARGET_ADDR(7'h50), .NUM_REGS(4)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda),
    .rd_idx(rd_idx), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitors of the write strobe and of SDA being pulled low by the target.
  int         wv_cnt = 0;
  int         bb_cnt = 0;
  int         dut_low_cnt = 0;
  logic       wv_prev = 1'b0;
  logic [1:0] last_idx = 2'd0;
  logic [7:0] last_data = 8'h00;
  always @(posedge clk) begin
    if (wr_valid) begin
      wv_cnt    <= wv_cnt + 1;
      last_idx  <= wr_idx;
      last_data <= wr_data;
    end
    if (wr_valid && wv_prev) bb_cnt <= bb_cnt + 1;
    wv_prev <= wr_valid;
    if (!m_oe && sda === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();  // also used as repeated START
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; m_oe = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #Q; scl = 1'b1; #Q; m_oe = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_oe = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic peek(input logic [1:0] idx, output logic [7:0] v);
    rd_idx = idx;
    @(negedge clk);
    v = rd_data;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         wv0, low0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write: reg1 = 0x5A
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'hA0, ack); chk("w_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h01, ack); chk("w_ptr_ack", 32'(ack), 32'd0);
    send_byte(8'h5A, ack); chk("w_data_ack", 32'(ack), 32'd0);
    chk("w_busy_hi", 32'(busy), 32'd1);
    bus_stop();
    repeat (4) @(negedge clk);
    chk("w_busy_lo", 32'(busy), 32'd0);
    chk("w_wv_count", 32'(wv_cnt - wv0), 32'd1);
    chk("w_wr_idx", 32'(last_idx), 32'd1);
    chk("w_wr_data", 32'(last_data), 32'h5A);
    peek(2'd1, d); chk("w_reg1", 32'(d), 32'h5A);

    // Burst write wrapping 3 -> 0
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    send_byte(8'h11, ack);
    chk("b_idx0", 32'(last_idx), 32'd3);
    chk("b_data0", 32'(last_data), 32'h11);
    send_byte(8'h22, ack);
    chk("b_idx1", 32'(last_idx), 32'd0);
    chk("b_data1", 32'(last_data), 32'h22);
    bus_stop();
    chk("b_wv_count", 32'(wv_cnt - wv0), 32'd2);
    peek(2'd3, d); chk("b_reg3", 32'(d), 32'h11);
    peek(2'd0, d); chk("b_reg0", 32'(d), 32'h22);

    // Preload reg2/reg3, then random read with repeated START
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    send_byte(8'hC3, ack);
    send_byte(8'h3C, ack);
    bus_stop();
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h02, ack);
    bus_start();
    send_byte(8'hA1, ack); chk("r_addr_ack", 32'(ack), 32'd0);
    recv_byte(d, 1'b0);    chk("r_byte0", 32'(d), 32'hC3);
    recv_byte(d, 1'b1);    chk("r_byte1", 32'(d), 32'h3C);
    chk("r_sda_released", 32'(sda), 32'd1);
    chk("r_busy_nack", 32'(busy), 32'd0);
    bus_stop();
    chk("r_no_wv", 32'(wv_cnt - wv0), 32'd0);

    // Address mismatch
    wv0 = wv_cnt; low0 = dut_low_cnt;
    bus_start();
    send_byte(8'hA2, ack); chk("m_nack", 32'(ack), 32'd1);
    chk("m_busy", 32'(busy), 32'd0);
    send_byte(8'h01, ack);
    send_byte(8'h77, ack);
    bus_stop();
    chk("m_sda_never_low", 32'(dut_low_cnt - low0), 32'd0);
    chk("m_no_wv", 32'(wv_cnt - wv0), 32'd0);
    peek(2'd1, d); chk("m_reg1", 32'(d), 32'h5A);

    // Abort after 4 data bits
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h00, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    chk("a_busy_hi", 32'(busy), 32'd1);
    bus_stop();
    chk("a_busy_lo", 32'(busy), 32'd0);
    chk("a_no_wv", 32'(wv_cnt - wv0), 32'd0);
    peek(2'd0, d); chk("a_reg0", 32'(d), 32'h22);

    // Reset while the target drives the MSB (0) of reg1 = 0x5A
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h01, ack);
    bus_start();
    send_byte(8'hA1, ack); chk("x_addr_ack", 32'(ack), 32'd0);
    chk("x_sda_driven", 32'(sda), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("x_sda_released", 32'(sda), 32'd1);
    chk("x_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), d);
      chk($sformatf("x_reg%0d", i), 32'(d), 32'd0);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_start();
    send_byte(8'hA0, ack); chk("x_post_ack", 32'(ack), 32'd0);
    chk("x_post_busy", 32'(busy), 32'd1);
    bus_stop();
    chk("x_post_busy_lo", 32'(busy), 32'd0);

    chk("wv_never_back_to_back", 32'(bb_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (responder) with a small byte-wide register file, answering the I2C master on the shared `scl`/`sda` bus. It supports register-pointer writes, burst writes and burst reads with an auto-incrementing pointer. A local read port exposes register contents to on-chip logic. A write-notify strobe reports every byte the master writes.

## Interface
- `TARGET_ADDR`, 7'h50, 7-bit bus address this block answers to
- `NUM_REGS`, 4, number of 8-bit registers; power of two, 2..256; pointer width `PW = log2(NUM_REGS)`
- `clk`  input  1  system clock; must run at ≥ 16× SCL frequency
- `reset_n`  input  1  asynchronous, active-low reset
- `scl`  input  1  bus clock driven by the master
- `sda`  inout  1  open-drain data; block drives only 1'b0 or 1'bz
- `rd_idx`  input  PW  local read-port register index
- `rd_data`  output  8  contents of register `rd_idx`; combinational
- `wr_valid`  output  1  one-clk pulse when the master writes a data byte
- `wr_idx`  output  PW  register written; valid with `wr_valid`
- `wr_data`  output  8  byte written; valid with `wr_valid`
- `busy`  output  1  high from address match until STOP or NACK-terminated transfer end

## Operation
- Input conditioning:
  - `scl` and `sda` pass through 2-flop synchronizers plus one history flop each.
  - All protocol decisions use the synchronized values.
- Conditions:
  - START: sync `sda` falls while sync `scl` is high.
  - STOP: sync `sda` rises while sync `scl` is high.
  - Bits are sampled on sync `scl` rising edges.
  - The block changes `sda` only on sync `scl` falling edges.
- State machine: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE → ADDR on START.
- ADDR:
  - Shift in 8 bits, MSB first.
  - If bits[7:1] == TARGET_ADDR: enter ADDR_ACK and drive `sda` low from the next falling edge until the following falling edge. `busy` = 1.
  - On mismatch: WAIT_STOP, `sda` never driven.
- After ADDR_ACK:
  - R/W = 0 → PTR.
  - R/W = 1 → RDATA; the byte at the pointer is loaded on the ACK-release falling edge and its MSB is driven at that same edge.
- PTR: shift in 8 bits; pointer ← byte[PW-1:0] (upper bits ignored); ACK; → WDATA.
- WDATA:
  - On the 8th rising edge: reg[ptr] ← byte; `wr_valid` pulses the next clk with `wr_idx` = old ptr; ptr ← ptr+1 mod NUM_REGS.
  - ACK, then back to WDATA.
- RDATA:
  - Each falling edge drives the next bit; a bit value of 1 releases `sda` (1'bz).
  - After the 8th bit, `sda` is released on the falling edge. → RDATA_ACK.
- RDATA_ACK:
  - Sample the master's bit on the rising edge.
  - 0 (ACK): ptr+1 mod NUM_REGS, load the next byte, → RDATA.
  - 1 (NACK): → WAIT_STOP, `busy` = 0.
- WAIT_STOP: ignore bits until STOP or START.
- Repeated START, from any state, including mid-byte:
  - → ADDR, bit counter cleared, `sda` released.
  - Pointer retained, which allows pointer-write then Sr-read.
- STOP, from any state: → IDLE, `sda` released, `busy` = 0.
- A STOP or START mid-byte in WDATA discards the partial byte; no write, no `wr_valid`.
- General call (address 0) is not supported; it is treated as a mismatch.
- Clock stretching is never performed.

## Timing
- Reset values:
  - state IDLE, all registers 8'h00, pointer 0.
  - `sda` = 1'bz, `wr_valid` = 0, `wr_idx` = 0, `wr_data` = 0, `busy` = 0.
  - `rd_data` = reg[`rd_idx`], i.e. 0.
- Reset is asynchronous: asserting `reset_n` releases `sda` within the same cycle, without waiting for a `clk` edge.
- Detection latency: 3 clk from a pin edge to internal edge detect.
- `sda` output change: ≤ 4 clk after the `scl` pin falling edge; well inside the SCL low time at ≥ 16×.
- `wr_valid`: 1 clk wide, asserted 4 clk after the `scl` pin rising edge of the 8th data bit; never back-to-back.
- Register update is visible on `rd_data` in the same cycle `wr_valid` is high.
- Pointer wrap: NUM_REGS−1 → 0, for both burst write and burst read.

## Test plan
- Write: START, 0xA0 (ACK), ptr 0x01 (ACK), data 0x5A (ACK), STOP → reg1 = 0x5A; exactly one `wr_valid` with `wr_idx`=1, `wr_data`=0x5A; `busy` falls after STOP.
- Burst write with wrap: ptr 0x03, data 0x11, 0x22 → reg3 = 0x11, reg0 = 0x22; two `wr_valid` pulses, idx 3 then 0.
- Random read:
  - Preload reg2 = 0xC3, reg3 = 0x3C.
  - Sequence: START, 0xA0, ptr 0x02, Sr, 0xA1, master ACK after byte 1, NACK after byte 2, STOP.
  - Required: `sda` carries 0xC3 then 0x3C MSB-first; `sda` released after the NACK; no `wr_valid`.
- Address mismatch: START, 0xA2, ptr, data, STOP → `sda` never low; no writes; `busy` stays 0.
- Abort mid-byte: START, 0xA0, ptr 0x00, 4 data bits, STOP → reg0 unchanged; no `wr_valid`; state IDLE.
- Reset mid-read: assert `reset_n` low while the block drives a 0 data bit → `sda` = 1'bz immediately; all registers read 0 via `rd_data`; a following START, 0xA0 is ACKed normally.
